sht40_frame_check: RTL

Receive-side framing and CRC stage for the SHT40 I2C read path. Sits directly downstream of the I2C master/SCL/SDA engine: it consumes the six bytes clocked in during a measurement read, as temperature MSB, LSB, CRC and then humidity MSB, LSB, CRC. It checks each CRC-8 bit-serially and publishes the raw 16-bit temperature and humidity words as an atomic pair only when both CRCs pass. It also keeps a saturating error count for the processor side.

---
 rtl/sht40_frame_check.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sht40_frame_check.sv
// sht40_frame_check: CRC-8 check and atomic publish of SHT40 temperature/humidity frames.
// Ports: clk, rst_n (sync, active-low); Frame_Start, Byte_In[7:0], Byte_Valid from the I2C master;
// Busy, Temp_Raw[15:0], Hum_Raw[15:0], Data_Valid, Crc_Error, Overrun_Error, Error_Count[7:0] out.
module sht40_frame_check (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Frame_Start,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Busy,
  output logic [15:0] Temp_Raw,
  output logic [15:0] Hum_Raw,
  output logic        Data_Valid,
  output logic        Crc_Error,
  output logic        Overrun_Error,
  output logic [7:0]  Error_Count
);
  typedef enum logic [1:0] {S_WAIT, S_CRC, S_CMP, S_ABORT} state_t;
  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d, bit_q, bit_d;
  logic [7:0]  crc_q, crc_d, sh_q, sh_d, err_cnt_q, err_cnt_d;
  logic [15:0] th_q, th_d, hh_q, hh_d, temp_q, temp_d, hum_q, hum_d;
  logic        dv_q, dv_d, cerr_q, cerr_d, ovr_q, ovr_d;
  assign Busy          = (state_q == S_CRC) || (state_q == S_CMP);
  assign Temp_Raw      = temp_q;
  assign Hum_Raw       = hum_q;
  assign Data_Valid    = dv_q;
  assign Crc_Error     = cerr_q;
  assign Overrun_Error = ovr_q;
  assign Error_Count   = err_cnt_q;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    crc_d   = crc_q;
    sh_d    = sh_q;
    th_d    = th_q;
    hh_d    = hh_q;
    temp_d  = temp_q;
    hum_d   = hum_q;
    dv_d    = 1'b0;
    cerr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (Frame_Start) begin
      state_d = S_WAIT;
      idx_d   = 3'd0;
      crc_d   = 8'hFF;
    end else if (Byte_Valid && Busy) begin
      ovr_d   = 1'b1;
      state_d = S_ABORT;
    end else begin
      case (state_q)
        S_WAIT: if (Byte_Valid) begin
          sh_d  = Byte_In;
          bit_d = 3'd0;
          if (idx_q == 3'd2 || idx_q == 3'd5) state_d = S_CMP;
          else begin
            state_d = S_CRC;
            if (idx_q == 3'd0) th_d[15:8] = Byte_In;
            if (idx_q == 3'd1) th_d[7:0]  = Byte_In;
            if (idx_q == 3'd3) hh_d[15:8] = Byte_In;
            if (idx_q == 3'd4) hh_d[7:0]  = Byte_In;
          end
        end
        S_CRC: begin
          crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ sh_q[7]) ? 8'h31 : 8'h00);
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            idx_d   = idx_q + 3'd1;
            state_d = S_WAIT;
          end
        end
        S_CMP: if (sh_q == crc_q) begin
          state_d = S_WAIT;
          crc_d   = 8'hFF;
          idx_d   = (idx_q == 3'd5) ? 3'd0 : 3'd3;
          if (idx_q == 3'd5) begin
            temp_d = th_q;
            hum_d  = hh_q;
            dv_d   = 1'b1;
          end
        end else begin
          cerr_d  = 1'b1;
          state_d = S_ABORT;
        end
        default: ;
      endcase
    end
    err_cnt_d = ((cerr_d || ovr_d) && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_ABORT;
      idx_q     <= 3'd0;
      bit_q     <= 3'd0;
      crc_q     <= 8'hFF;
      sh_q      <= 8'h00;
      th_q      <= 16'h0;
      hh_q      <= 16'h0;
      temp_q    <= 16'h0;
      hum_q     <= 16'h0;
      dv_q      <= 1'b0;
      cerr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      err_cnt_q <= 8'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      bit_q     <= bit_d;
      crc_q     <= crc_d;
      sh_q      <= sh_d;
      th_q      <= th_d;
      hh_q      <= hh_d;
      temp_q    <= temp_d;
      hum_q     <= hum_d;
      dv_q      <= dv_d;
      cerr_q    <= cerr_d;
      ovr_q     <= ovr_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule
